// File: rtl/music_sel_if.sv
// music_sel_if: selection request and player-status bundle around music_sel_ctrl.
interface music_sel_if #(
    parameter int SEL_W = 4
);
    logic [SEL_W-1:0] data_sel;
    logic             data_sel_en;
    logic             data_stop;
    logic [SEL_W-1:0] select_music;
    logic             play_active;
    logic             done_pulse;
    logic             pending_valid;
    modport master (
        output data_sel, data_sel_en, data_stop,
        input  select_music, play_active, done_pulse, pending_valid
    );
    modport slave (
        input  data_sel, data_sel_en, data_stop,
        output select_music, play_active, done_pulse, pending_valid
    );
endinterface

// File: rtl/music_sel_ctrl.sv
// music_sel_ctrl: delayed-strobe music selector that plays each code for a timed window.
// Define MUSIC_SEL_QUEUE_EN to add a one-entry pending request register.
module music_sel_ctrl #(
    parameter int SEL_W      = 4,
    parameter int TICK_DIV   = 25_000_000,
    parameter int HOLD_TICKS = 5,
    parameter int EN_DLY     = 4
) (
    input logic        s_clk,
    input logic        s_rst_n,
    music_sel_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int TW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_LAST = TW'(HOLD_TICKS - 1);
    typedef enum logic {IDLE, PLAY} state_t;
    state_t           state;
    logic [EN_DLY-1:0] en_dly;
    logic             en_last;
    logic             armed;
    logic [PW-1:0]    presc;
    logic [TW-1:0]    tick;
    logic [SEL_W-1:0] sel;
    logic             done;
    logic             req;
    logic             wrap;
    logic             expire;
    logic             kill;
`ifdef MUSIC_SEL_QUEUE_EN
    logic [SEL_W-1:0] pend;
    logic             pend_v;
    assign bus.pending_valid = pend_v;
`else
    assign bus.pending_valid = 1'b0;
`endif
    assign req    = en_dly[EN_DLY-1] & ~en_last;
    assign wrap   = presc == P_LAST;
    assign expire = state == PLAY && wrap && tick == T_LAST;
    assign kill   = bus.data_stop || (req && bus.data_sel == '0);
    assign bus.select_music = sel;
    assign bus.play_active  = state == PLAY;
    assign bus.done_pulse   = done;
    // armed blocks a strobe held high across reset release until it has been seen low
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            en_dly  <= '0;
            en_last <= 1'b0;
            armed   <= 1'b0;
            presc   <= '0;
            tick    <= '0;
            sel     <= '0;
            done    <= 1'b0;
`ifdef MUSIC_SEL_QUEUE_EN
            pend    <= '0;
            pend_v  <= 1'b0;
`endif
        end else begin
            en_dly  <= EN_DLY'({en_dly, bus.data_sel_en & armed});
            en_last <= en_dly[EN_DLY-1];
            armed   <= armed | ~bus.data_sel_en;
            done    <= 1'b0;
            if (kill) begin
                state <= IDLE;
                sel   <= '0;
                presc <= '0;
                tick  <= '0;
`ifdef MUSIC_SEL_QUEUE_EN
                pend_v <= 1'b0;
`endif
            end else if (req && state == IDLE) begin
                state <= PLAY;
                sel   <= bus.data_sel;
                presc <= '0;
                tick  <= '0;
            end else if (state == PLAY) begin
`ifdef MUSIC_SEL_QUEUE_EN
                if (expire) begin
                    done   <= 1'b1;
                    presc  <= '0;
                    tick   <= '0;
                    pend_v <= 1'b0;
                    if (req || pend_v) begin
                        sel <= req ? bus.data_sel : pend;
                    end else begin
                        state <= IDLE;
                        sel   <= '0;
                    end
                end else begin
                    presc <= wrap ? '0 : presc + 1'b1;
                    tick  <= wrap ? tick + 1'b1 : tick;
                    if (req) begin
                        pend   <= bus.data_sel;
                        pend_v <= 1'b1;
                    end
                end
`else
                if (req) begin
                    sel   <= bus.data_sel;
                    presc <= '0;
                    tick  <= '0;
                end else if (expire) begin
                    done  <= 1'b1;
                    state <= IDLE;
                    sel   <= '0;
                    presc <= '0;
                    tick  <= '0;
                end else begin
                    presc <= wrap ? '0 : presc + 1'b1;
                    tick  <= wrap ? tick + 1'b1 : tick;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_music_sel_ctrl.sv
// tb_music_sel_ctrl: scoreboard bench; expected output events are queued with the stimulus
// and matched against select_music/done_pulse changes (TICK_DIV=4, HOLD_TICKS=3, EN_DLY=4).
module tb_music_sel_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int prev_sel = 0;
    typedef struct {int cyc; int code; int done;} ev_t;
    ev_t exp_q[$];
    ev_t e;
    music_sel_if #(.SEL_W(4)) bus ();
    music_sel_ctrl #(.SEL_W(4), .TICK_DIV(4), .HOLD_TICKS(3), .EN_DLY(4)) dut (
        .s_clk(clk),
        .s_rst_n(rst_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string tag, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask
    task automatic push(int c, int code, int d);
        exp_q.push_back('{cyc: c, code: code, done: d});
    endtask
    task automatic wait_cyc(int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic pulse(int code, int n);
        wait_cyc(n);
        bus.data_sel = 4'(code);
        bus.data_sel_en = 1'b1;
        wait_cyc(n + 1);
        bus.data_sel_en = 1'b0;
    endtask
    task automatic drain(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (int'(bus.select_music) != prev_sel || bus.done_pulse) begin
            if (exp_q.size() == 0) begin
                chk("spurious_event", int'(bus.select_music), prev_sel);
            end else begin
                e = exp_q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_sel", int'(bus.select_music), e.code);
                chk("ev_done", int'(bus.done_pulse), e.done);
                chk("ev_play", int'(bus.play_active), int'(e.code != 0));
            end
            prev_sel = int'(bus.select_music);
        end
    end
    initial begin
        int t;
        bus.data_sel = '0;
        bus.data_sel_en = 1'b0;
        bus.data_stop = 1'b0;
        wait_cyc(3);
        chk("rst_sel", int'(bus.select_music), 0);
        chk("rst_play", int'(bus.play_active), 0);
        chk("rst_done", int'(bus.done_pulse), 0);
        chk("rst_pend", int'(bus.pending_valid), 0);
        rst_n = 1'b1;
        // basic play window
        t = cyc + 2;
        push(t + 5, 5, 0);
        push(t + 17, 0, 1);
        pulse(5, t);
        drain(40);
        // second request arriving at cycle 6 of the window
        t = cyc + 2;
        push(t + 5, 5, 0);
`ifdef MUSIC_SEL_QUEUE_EN
        push(t + 17, 9, 1);
        push(t + 29, 0, 1);
`else
        push(t + 12, 9, 0);
        push(t + 24, 0, 1);
`endif
        pulse(5, t);
        pulse(9, t + 7);
        wait_cyc(t + 13);
`ifdef MUSIC_SEL_QUEUE_EN
        chk("pend_set", int'(bus.pending_valid), 1);
`else
        chk("pend_set", int'(bus.pending_valid), 0);
`endif
        drain(60);
        chk("pend_after", int'(bus.pending_valid), 0);
        // data_stop coincident with a req
        t = cyc + 2;
        push(t + 5, 5, 0);
        push(t + 13, 0, 0);
        pulse(5, t);
        pulse(7, t + 8);
        wait_cyc(t + 12);
        bus.data_stop = 1'b1;
        wait_cyc(t + 13);
        bus.data_stop = 1'b0;
        wait_cyc(t + 14);
        chk("stop_pend", int'(bus.pending_valid), 0);
        drain(40);
        // code 0 request stops immediately
        t = cyc + 2;
        push(t + 5, 5, 0);
        push(t + 13, 0, 0);
        pulse(5, t);
        pulse(0, t + 8);
        wait_cyc(t + 14);
        chk("zero_pend", int'(bus.pending_valid), 0);
        drain(40);
        // reset mid-window with the strobe held high
        t = cyc + 2;
        push(t + 5, 5, 0);
        push(t + 10, 0, 0);
        pulse(5, t);
        wait_cyc(t + 9);
        bus.data_sel_en = 1'b1;
        wait_cyc(t + 10);
        rst_n = 1'b0;
        wait_cyc(t + 12);
        rst_n = 1'b1;
        wait_cyc(t + 27);
        chk("hold_sel", int'(bus.select_music), 0);
        chk("hold_play", int'(bus.play_active), 0);
        chk("hold_done", int'(bus.done_pulse), 0);
        chk("hold_pend", int'(bus.pending_valid), 0);
        bus.data_sel_en = 1'b0;
        push(t + 35, 3, 0);
        push(t + 47, 0, 1);
        pulse(3, t + 30);
        drain(60);
        // req landing exactly on the expiry cycle
        t = cyc + 2;
        push(t + 5, 5, 0);
`ifdef MUSIC_SEL_QUEUE_EN
        push(t + 17, 6, 1);
`else
        push(t + 17, 6, 0);
`endif
        push(t + 29, 0, 1);
        pulse(5, t);
        pulse(6, t + 12);
        drain(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/music_sel_ctrl.md
MUSIC_SEL_CTRL -- requirements
Module: music_sel_ctrl

Interface
REQ-001 Parameter SEL_W, default 4, shall set the width of the selection code.
REQ-002 Parameter TICK_DIV, default 25_000_000, shall set the prescaler period in s_clk cycles per tick; legal range 2 or more.
REQ-003 Parameter HOLD_TICKS, default 5, shall set the ticks per play window; legal range 1 or more.
REQ-004 Parameter EN_DLY, default 4, shall set the data_sel_en delay depth in cycles; legal range 1 or more.
REQ-005 s_clk  in  1  sole clock; all logic shall be rising-edge.
REQ-006 s_rst_n  in  1  asynchronous, active-low reset.
REQ-007 data_sel  in  SEL_W  requested selection code; code 0 means stop.
REQ-008 data_sel_en  in  1  request strobe, level or pulse.
REQ-009 data_stop  in  1  synchronous abort request.
REQ-010 select_music  out  SEL_W  current selection to the player; 0 = silent.
REQ-011 play_active  out  1  high while in PLAY.
REQ-012 done_pulse  out  1  one-cycle pulse on natural window expiry.
REQ-013 pending_valid  out  1  queued request present; constant 0 when the queue is compiled out.

Function
REQ-014 data_sel_en shall pass through an EN_DLY-stage shift register; req shall be the rising edge of the last stage.
- REQ-015 data_sel shall be sampled in the req cycle, so it must be stable from the strobe edge for EN_DLY+1 cycles.
- REQ-016 The FSM shall have exactly two states: IDLE and PLAY.
- REQ-017 IDLE + req with code != 0 -> PLAY; select_music = code; prescaler and tick count = 0.
- REQ-018 In PLAY the prescaler shall count 0..TICK_DIV-1 and wrap; at each wrap the tick count shall increment.
- REQ-019 Expiry: wrap while tick count = HOLD_TICKS-1; the window shall be exactly HOLD_TICKS*TICK_DIV cycles from load.
- REQ-020 On expiry with nothing pending: select_music = 0, state -> IDLE, done_pulse = 1 for one cycle.
- REQ-021 data_stop, or req with code 0, in any state: select_music = 0, IDLE, counters and pending cleared, no done_pulse.
- REQ-022 data_stop shall take priority over req and expiry in the same cycle.
- REQ-023 Without the queue, req in PLAY (code != 0) shall load the new code and restart both counters; if coincident with expiry, req wins and there is no done_pulse.
- REQ-024 In IDLE the counters shall hold 0 and done_pulse shall be 0.
- REQ-025 Counter widths shall be $clog2-derived; the counters shall never exceed their terminal values.

Reset
REQ-026 On s_rst_n low: select_music = 0, play_active = 0, done_pulse = 0, pending_valid = 0, delay line = 0, counters = 0, state IDLE.
REQ-027 Reset mid-PLAY shall discard the current selection and any pending one; data_sel_en held high through reset release shall produce no req until it falls and rises again.

Configuration
REQ-028 Macro MUSIC_SEL_QUEUE_EN defined: a one-entry pending register is present.
- REQ-029 With MUSIC_SEL_QUEUE_EN, req in PLAY (code != 0) shall store the code in pending (a newer request overwrites), set pending_valid, and leave the timer running.
- REQ-030 With MUSIC_SEL_QUEUE_EN, expiry with pending valid shall pulse done_pulse, load the pending code, restart the counters, stay in PLAY and clear pending_valid in the same cycle.
- REQ-031 MUSIC_SEL_QUEUE_EN undefined: no pending storage; REQ-023 applies.

Verification (TICK_DIV=4, HOLD_TICKS=3, EN_DLY=4; window = 12 cycles)
REQ-032 data_sel=5, one-cycle data_sel_en at cycle 0 -> select_music=5 at cycle 5; done_pulse and select_music=0 12 cycles later.
REQ-033 Playing code 5, new request code 9 at cycle 6 of the window:
- queue undefined -> code 9 plays for a full 12 cycles from its load;
- queue defined -> pending_valid=1, 9 loads at expiry together with done_pulse.
REQ-034 data_stop asserted during PLAY, coincident with a req -> select_music=0 next cycle, no done_pulse, pending_valid=0.
REQ-035 Request with code 0 during PLAY -> immediate stop identical to REQ-034.
REQ-036 s_rst_n pulsed low mid-window with data_sel_en held high -> all outputs 0, no restart until data_sel_en toggles.
REQ-037 Without the queue, req edge coincident with the expiry cycle -> new code loaded, done_pulse stays 0, window restarts at 12 cycles.
